// File: rtl/jenc_ebr_pkg.sv
// rtl/jenc_ebr_pkg.sv - shared FSM state and byte-count encoding for the EBR read unpacker
package jenc_ebr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ebr_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;

    // Final-word byte count: a field value of 0 stands for a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] enc);
        return (enc == 2'd0) ? 3'd4 : {1'b0, enc};
    endfunction

endpackage

// File: rtl/ebr_rd_word_fifo2.sv
// rtl/ebr_rd_word_fifo2.sv - two-entry word FIFO between the RAM read port and the byte serialiser
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i         write push_data_i this cycle (caller guarantees a free slot)
//   push_data_i    word to store
//   pop_i          drop the head word (caller guarantees not empty)
//   head_o         oldest stored word
//   count_o        number of stored words, 0..2
module ebr_rd_word_fifo2 #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= push_data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_i) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_i, pop_i})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/ebr_rd_byte_unpacker.sv
// rtl/ebr_rd_byte_unpacker.sv - reads a run of RAM words and streams them out byte by byte
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             begin a transfer (ignored unless idle)
//   base_addr_i         first word address
//   nwords_i            number of words, 0..2^AW
//   last_bytes_i        valid bytes in the final word, 0 = all four
//   rd_en_o, rd_addr_o  RAM read request
//   rd_data_i           RAM data, valid the cycle after rd_en_o
//   byte_o, valid_o, ready_i, last_o   byte stream with handshake
//   busy_o              transfer in progress (RUN or DONE)
//   done_o              one-cycle completion pulse
module ebr_rd_byte_unpacker
    import jenc_ebr_pkg::*;
#(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW:0]   nwords_i,
    input  logic [1:0]    last_bytes_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [DW-1:0] rd_data_i,
    output logic [7:0]    byte_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o,
    output logic          busy_o,
    output logic          done_o
);

    ebr_state_e    state;
    ebr_state_e    state_nxt;

    logic [AW:0]   issue_left;    // reads still to be requested
    logic [AW:0]   emit_left;     // words still to be serialised
    logic [AW-1:0] rd_addr;
    logic [1:0]    last_bytes_r;
    logic [1:0]    byte_idx;
    logic          rd_pending;    // a read was issued last cycle; its data is on rd_data_i now

    logic [DW-1:0] head;
    logic [1:0]    fifo_count;
    logic          start_ok;
    logic          final_word;
    logic [2:0]    word_bytes;
    logic          word_end;
    logic          fire;
    logic          fifo_pop;

    assign start_ok   = (state == ST_IDLE) && start_i;
    assign final_word = (emit_left == (AW+1)'(1));
    assign word_bytes = final_word ? byte_count(last_bytes_r) : 3'(BYTES_PER_WORD);
    assign word_end   = ({1'b0, byte_idx} == (word_bytes - 3'd1));
    assign fire       = valid_o && ready_i;
    assign fifo_pop   = fire && word_end;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i) state_nxt = (nwords_i == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (fire && last_o) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A read is only issued when the word it returns is guaranteed a FIFO slot,
    // so captured data never has to be dropped under backpressure.
    always_comb begin
        rd_en_o = (state == ST_RUN) && (issue_left != '0) &&
                  ((fifo_count + {1'b0, rd_pending}) < 2'd2);
        valid_o = (state == ST_RUN) && (fifo_count != 2'd0);
        busy_o  = (state == ST_RUN) || (state == ST_DONE);
        done_o  = (state == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_left   <= '0;
            emit_left    <= '0;
            rd_addr      <= '0;
            last_bytes_r <= 2'd0;
            byte_idx     <= 2'd0;
            rd_pending   <= 1'b0;
        end else begin
            rd_pending <= rd_en_o;
            if (start_ok) begin
                issue_left   <= nwords_i;
                emit_left    <= nwords_i;
                rd_addr      <= base_addr_i;
                last_bytes_r <= last_bytes_i;
                byte_idx     <= 2'd0;
            end else begin
                if (rd_en_o) begin
                    rd_addr    <= rd_addr + AW'(1);   // wraps at the top of the RAM
                    issue_left <= issue_left - (AW+1)'(1);
                end
                if (fire) begin
                    if (word_end) begin
                        byte_idx  <= 2'd0;
                        emit_left <= emit_left - (AW+1)'(1);
                    end else begin
                        byte_idx  <= byte_idx + 2'd1;
                    end
                end
            end
        end
    end

    ebr_rd_word_fifo2 #(
        .DW (DW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (rd_pending),
        .push_data_i (rd_data_i),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign rd_addr_o = rd_addr;
    assign byte_o    = valid_o ? head[{byte_idx, 3'b000} +: 8] : 8'h00;
    assign last_o    = valid_o && final_word && word_end;

endmodule

// File: tb/tb_ebr_rd_byte_unpacker.sv
// tb/tb_ebr_rd_byte_unpacker.sv - scoreboard testbench for ebr_rd_byte_unpacker
module tb_ebr_rd_byte_unpacker;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [5:0]  base_addr_i;
    logic [6:0]  nwords_i;
    logic [1:0]  last_bytes_i;
    logic        rd_en_o;
    logic [5:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic [7:0]  byte_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        busy_o;
    logic        done_o;

    ebr_rd_byte_unpacker #(.AW(6), .DW(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .nwords_i     (nwords_i),
        .last_bytes_i (last_bytes_i),
        .rd_en_o      (rd_en_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_i    (rd_data_i),
        .byte_o       (byte_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic       eow;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [64];
    logic [5:0]  addr_log[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_en_cnt = 0;
    int valid_cnt = 0;
    int fire_cnt = 0;
    int issued = 0;
    int consumed = 0;
    int first_valid_cyc = 0;
    logic rand_ready = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // EBR model: data presented the cycle after the read enable
    always @(posedge clk) begin
        if (rd_en_o) rd_data_i <= mem[rd_addr_o];
    end

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and checks protocol rules
    initial begin : monitor
        logic       prev_stall;
        logic [7:0] prev_byte;
        logic       expect_done;
        logic       waiting_first;
        exp_t       e;
        prev_stall    = 1'b0;
        prev_byte     = 8'h00;
        expect_done   = 1'b0;
        waiting_first = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                exp_q.delete();
                prev_stall    = 1'b0;
                expect_done   = 1'b0;
                waiting_first = 1'b0;
                consumed      = issued;
            end else begin
                if (done_o || expect_done) check("done_pulse", 32'(done_o), 32'(expect_done));
                expect_done = 1'b0;
                if (start_i && !busy_o) begin
                    waiting_first = 1'b1;
                    if (nwords_i == 7'd0) expect_done = 1'b1;
                end
                if (prev_stall) begin
                    check("hold_valid", 32'(valid_o), 32'd1);
                    check("hold_byte", 32'(byte_o), 32'(prev_byte));
                end
                if (last_o) check("last_qualified", 32'(valid_o), 32'd1);
                if (rd_en_o) begin
                    rd_en_cnt++;
                    issued++;
                    addr_log.push_back(rd_addr_o);
                    n_cmp++;
                    if (issued - consumed > 2) begin
                        n_err++;
                        $display("FAIL outstanding act=%0d req<=2 t=%0t", issued - consumed, $time);
                    end
                end
                if (valid_o) begin
                    valid_cnt++;
                    if (waiting_first) begin
                        first_valid_cyc = cyc;
                        waiting_first   = 1'b0;
                    end
                end
                if (valid_o && ready_i) begin
                    fire_cnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte act=%02h req=none t=%0t", byte_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'(byte_o), 32'(e.b));
                        check("last", 32'(last_o), 32'(e.last));
                        if (e.eow) consumed++;
                        if (e.last) expect_done = 1'b1;
                    end
                end
                prev_stall = valid_o && !ready_i;
                prev_byte  = byte_o;
            end
        end
    end

    task automatic push_exp(input logic [7:0] b, input logic last, input logic eow);
        exp_t e;
        e.b = b; e.last = last; e.eow = eow;
        exp_q.push_back(e);
    endtask

    task automatic push_words(input int base, input int n, input int lb);
        for (int w = 0; w < n; w++) begin
            logic [31:0] word;
            int nb;
            word = mem[(base + w) & 63];
            nb = (w == n - 1) ? ((lb == 0) ? 4 : lb) : 4;
            for (int b = 0; b < nb; b++)
                push_exp(word[8*b +: 8], (w == n - 1) && (b == nb - 1), b == nb - 1);
        end
    endtask

    task automatic start_xfer(input int base, input int n, input int lb, output int t0);
        @(posedge clk);
        #1;
        base_addr_i  = 6'(base);
        nwords_i     = 7'(n);
        last_bytes_i = 2'(lb);
        start_i      = 1'b1;
        t0           = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int tdone);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done_o && k < budget);
        tdone = cyc;
        if (!done_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout act=no_done req=done_within_%0d", name, budget);
        end
    endtask

    initial begin : stimulus
        int t0, t1, tmp, a0, r0, f0, v0;
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; nwords_i = '0; last_bytes_i = '0;
        rd_data_i = '0;
        for (int i = 0; i < 64; i++) mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} ^ 32'h5A000000;
        mem[0]  = 32'h44332211;
        mem[1]  = 32'h88776655;
        mem[62] = 32'hA3A2A1A0;
        mem[63] = 32'hB3B2B1B0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("reset_outputs", {rd_en_o, valid_o, last_o, busy_o, done_o, rd_addr_o, byte_o}, 32'd0);

        // two full words, ready always high
        push_exp(8'h11, 0, 0); push_exp(8'h22, 0, 0); push_exp(8'h33, 0, 0); push_exp(8'h44, 0, 1);
        push_exp(8'h55, 0, 0); push_exp(8'h66, 0, 0); push_exp(8'h77, 0, 0); push_exp(8'h88, 1, 1);
        start_xfer(0, 2, 0, t0);
        wait_done("s1", 200, t1);
        check("s1_first_latency", 32'(first_valid_cyc - t0), 32'd3);
        check("s1_done_cycle", 32'(t1 - t0), 32'd11);
        check("s1_queue_empty", 32'(exp_q.size()), 32'd0);

        // address wrap
        a0 = addr_log.size();
        push_words(62, 4, 0);
        start_xfer(62, 4, 0, t0);
        wait_done("s2", 200, t1);
        check("s2_addr_count", 32'(addr_log.size() - a0), 32'd4);
        if (addr_log.size() - a0 == 4) begin
            check("s2_addr0", 32'(addr_log[a0]),   32'd62);
            check("s2_addr1", 32'(addr_log[a0+1]), 32'd63);
            check("s2_addr2", 32'(addr_log[a0+2]), 32'd0);
            check("s2_addr3", 32'(addr_log[a0+3]), 32'd1);
        end
        check("s2_queue_empty", 32'(exp_q.size()), 32'd0);

        // partial final word under random backpressure
        rand_ready = 1'b1;
        f0 = fire_cnt;
        push_words(10, 3, 1);
        start_xfer(10, 3, 1, t0);
        wait_done("s3", 600, t1);
        rand_ready = 1'b0;
        check("s3_byte_count", 32'(fire_cnt - f0), 32'd9);
        check("s3_queue_empty", 32'(exp_q.size()), 32'd0);

        // zero-length transfer
        repeat (2) @(posedge clk);
        r0 = rd_en_cnt; v0 = valid_cnt;
        start_xfer(7, 0, 0, t0);
        wait_done("s4", 20, t1);
        check("s4_done_cycle", 32'(t1 - t0), 32'd1);
        repeat (3) @(negedge clk);
        check("s4_no_rd_en", 32'(rd_en_cnt - r0), 32'd0);
        check("s4_no_valid", 32'(valid_cnt - v0), 32'd0);

        // reset in the middle of a 16-word transfer
        f0 = fire_cnt;
        push_words(20, 16, 0);
        start_xfer(20, 16, 0, t0);
        tmp = 0;
        while (fire_cnt < f0 + 5 && tmp < 200) begin
            @(posedge clk);
            tmp++;
        end
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("s5_reset_outputs", {rd_en_o, valid_o, last_o, busy_o, done_o, rd_addr_o, byte_o}, 32'd0);
        v0 = valid_cnt;
        repeat (4) @(negedge clk);
        check("s5_quiet_after_reset", 32'(valid_cnt - v0), 32'd0);
        push_words(5, 1, 3);
        start_xfer(5, 1, 3, t0);
        wait_done("s5_restart", 100, t1);
        check("s5_restart_done_cycle", 32'(t1 - t0), 32'd6);
        check("s5_queue_empty", 32'(exp_q.size()), 32'd0);

        // start re-pulsed while running
        r0 = rd_en_cnt; f0 = fire_cnt;
        push_words(30, 2, 2);
        start_xfer(30, 2, 2, t0);
        repeat (2) @(posedge clk);
        start_xfer(0, 5, 0, tmp);
        wait_done("s6", 200, t1);
        check("s6_done_cycle", 32'(t1 - t0), 32'd9);
        repeat (10) @(negedge clk);
        check("s6_rd_count", 32'(rd_en_cnt - r0), 32'd2);
        check("s6_byte_count", 32'(fire_cnt - f0), 32'd6);
        check("s6_idle_busy", 32'(busy_o), 32'd0);
        check("s6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
